// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//
// Handshake bundle around one pipeline stage register. Both sides of the
// stage live in one interface: the upstream offer (in_*) and the downstream
// presentation (out_*).
//
// Parameters:
//   DATA_W  width of the payload bundle
//   CTRL_W  width of the control bundle
//
// Signals:
//   in_valid   upstream offers a transfer
//   in_ready   stage can accept a transfer this cycle
//   in_data    upstream payload
//   in_ctrl    upstream control bits
//   out_valid  stage presents a valid entry
//   out_ready  downstream consumes the presented entry
//   out_data   presented payload
//   out_ctrl   presented control, zero whenever out_valid is low
//
// Modports:
//   master  the environment around the stage (drives offers and out_ready)
//   slave   the stage register itself
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register with a valid/ready handshake, synchronous
// flush and bubble insertion. A bubble always shows zero control bits so a
// downstream stage never sees a spurious write. The instantiating stage packs
// its own fields into in_data / in_ctrl.
//
// Optional feature: define PIPE_SKID_EN to add a one-entry skid register.
// in_ready then comes straight from a state bit, which cuts the
// out_ready -> in_ready path and keeps full throughput under backpressure.
// Without it, in_ready = !m_valid || out_ready.
//
// Parameters:
//   DATA_W  payload width
//   CTRL_W  control width
//   CNT_W   bubble counter width
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   flush       synchronous kill of every held entry
//   bus         handshake bundle (slave side)
//   bubble_cnt  saturating count of cycles with out_valid low since reset
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    // The encoding makes bit 0 the main-valid flag and bit 1 the skid-valid
    // flag, so both come straight out of flops.
`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;
`else
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;
`endif

    state_t            state_q;
    logic [DATA_W-1:0] m_data_q;
    logic [CTRL_W-1:0] m_ctrl_q;
`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] s_data_q;
    logic [CTRL_W-1:0] s_ctrl_q;
`endif
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_d;

    logic m_valid;
    logic in_ready;
    logic accept;
    logic consume;

    assign m_valid = state_q[0];

`ifdef PIPE_SKID_EN
    assign in_ready = !state_q[1];
`else
    assign in_ready = !m_valid || bus.out_ready;
`endif

    assign accept  = bus.in_valid && in_ready;
    assign consume = m_valid && bus.out_ready;

    // The counter looks at the registered valid so it counts bubbles the
    // downstream stage actually saw, and it sticks at all-ones.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!m_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Stage FSM and datapath. Flush only kills validity: payload registers
    // keep their last value so out_data stays stable while invalid, and
    // out_ctrl is masked below anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            m_data_q     <= '0;
            m_ctrl_q     <= '0;
`ifdef PIPE_SKID_EN
            s_data_q     <= '0;
            s_ctrl_q     <= '0;
`endif
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            if (flush) begin
                state_q <= EMPTY;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            state_q  <= FULL;
                            m_data_q <= bus.in_data;
                            m_ctrl_q <= bus.in_ctrl;
                        end
                    end
                    FULL: begin
                        if (consume) begin
                            if (accept) begin
                                m_data_q <= bus.in_data;
                                m_ctrl_q <= bus.in_ctrl;
                            end else begin
                                state_q <= EMPTY;
                            end
                        end
`ifdef PIPE_SKID_EN
                        else if (accept) begin
                            state_q  <= SKID;
                            s_data_q <= bus.in_data;
                            s_ctrl_q <= bus.in_ctrl;
                        end
`endif
                    end
`ifdef PIPE_SKID_EN
                    SKID: begin
                        if (consume) begin
                            state_q  <= FULL;
                            m_data_q <= s_data_q;
                            m_ctrl_q <= s_ctrl_q;
                        end
                    end
`endif
                    default: begin
                        state_q <= EMPTY;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = m_valid;
    assign bus.out_data  = m_data_q;
    assign bus.out_ctrl  = m_valid ? m_ctrl_q : '0;
    assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. A table of single-cycle vectors covers
// streaming, accept+consume in FULL and flush; hand-written sequences cover
// backpressure, reset in the middle of traffic and bubble counter saturation
// (a second instance with a 4-bit counter). Expectations follow the build:
// PIPE_SKID_EN selects the skid behaviour.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [15:0] bubbleCnt;

    logic        satReset;
    logic        satFlush;
    logic [3:0]  satCnt;

    int checks;
    int errors;

    pipe_stage_reg_if #(.DATA_W(8), .CTRL_W(4)) busIf ();
    pipe_stage_reg_if #(.DATA_W(8), .CTRL_W(4)) satIf ();

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .bus        (busIf),
        .bubble_cnt (bubbleCnt)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .CNT_W(4)) dutSat (
        .clk        (clk),
        .reset      (satReset),
        .flush      (satFlush),
        .bus        (satIf),
        .bubble_cnt (satCnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [7:0]  id;
        logic [3:0]  ic;
        logic        ordy;
        logic        eov;
        logic [7:0]  eod;
        logic [3:0]  eoc;
        logic        eir;
        logic [15:0] ebc;
    } vec_t;

    vec_t vecs [11];

    // One comparison, one counted check.
    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the rising edge pass and settle 1ns.
    // Inputs stay held afterwards, so in_ready is seen with them applied.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [7:0] id, input logic [3:0] ic, input logic ordy);
        reset              = rst;
        flush              = fl;
        busIf.in_valid     = iv;
        busIf.in_data      = id;
        busIf.in_ctrl      = ic;
        busIf.out_ready    = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic eov, input logic [7:0] eod,
                               input logic [3:0] eoc, input logic eir, input logic [15:0] ebc);
        checkVal({tag, ".out_valid"}, {15'd0, busIf.out_valid}, {15'd0, eov});
        checkVal({tag, ".out_data"}, {8'd0, busIf.out_data}, {8'd0, eod});
        checkVal({tag, ".out_ctrl"}, {12'd0, busIf.out_ctrl}, {12'd0, eoc});
        checkVal({tag, ".in_ready"}, {15'd0, busIf.in_ready}, {15'd0, eir});
        checkVal({tag, ".bubble_cnt"}, bubbleCnt, ebc);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        satReset = 1'b1;
        satFlush = 1'b0;
        satIf.in_valid  = 1'b0;
        satIf.in_data   = 8'h00;
        satIf.in_ctrl   = 4'h0;
        satIf.out_ready = 1'b0;
        reset    = 1'b1;
        flush    = 1'b0;
        busIf.in_valid  = 1'b0;
        busIf.in_data   = 8'h00;
        busIf.in_ctrl   = 4'h0;
        busIf.out_ready = 1'b0;

        //          rst   fl    iv    data   ctrl  ordy  eov   eod    eoc   eir   ebc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h11, 4'h1, 1'b1, 1'b1, 8'h11, 4'h1, 1'b1, 16'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h22, 4'h2, 1'b1, 1'b1, 8'h22, 4'h2, 1'b1, 16'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h33, 4'h3, 1'b1, 1'b1, 8'h33, 4'h3, 1'b1, 16'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h33, 4'h0, 1'b1, 16'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h33, 4'h0, 1'b1, 16'd2};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h01, 4'h5, 1'b1, 1'b1, 8'h01, 4'h5, 1'b1, 16'd3};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h02, 4'h6, 1'b1, 1'b1, 8'h02, 4'h6, 1'b1, 16'd3};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'hC4, 4'hB, 1'b1, 1'b1, 8'hC4, 4'hB, 1'b1, 16'd3};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h99, 4'hF, 1'b0, 1'b0, 8'hC4, 4'h0, 1'b1, 16'd3};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'hC4, 4'h0, 1'b1, 16'd4};

        // Reset, stream, accept+consume, flush with an offer pending
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].ordy);
            checkOutput($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eod, vecs[i].eoc,
                        vecs[i].eir, vecs[i].ebc);
        end

        // Backpressure: A5 held, 5A offered, then both drain in order
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 4'h1, 1'b0);
`ifdef PIPE_SKID_EN
        checkOutput("bp_load", 1'b1, 8'hA5, 4'h1, 1'b1, 16'd5);
`else
        checkOutput("bp_load", 1'b1, 8'hA5, 4'h1, 1'b0, 16'd5);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 4'h2, 1'b0);
        checkOutput("bp_offer", 1'b1, 8'hA5, 4'h1, 1'b0, 16'd5);
`ifdef PIPE_SKID_EN
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
`else
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 4'h2, 1'b0);
`endif
        checkOutput("bp_hold", 1'b1, 8'hA5, 4'h1, 1'b0, 16'd5);
`ifdef PIPE_SKID_EN
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
`else
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 4'h2, 1'b1);
`endif
        checkOutput("bp_release", 1'b1, 8'h5A, 4'h2, 1'b1, 16'd5);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        checkOutput("bp_drain", 1'b0, 8'h5A, 4'h0, 1'b1, 16'd5);

        // Reset while the stage is full and a second entry is pending/skidded
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h10, 4'h9, 1'b0);
`ifdef PIPE_SKID_EN
        checkOutput("rs_load", 1'b1, 8'h10, 4'h9, 1'b1, 16'd6);
`else
        checkOutput("rs_load", 1'b1, 8'h10, 4'h9, 1'b0, 16'd6);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20, 4'hA, 1'b0);
        checkOutput("rs_fill", 1'b1, 8'h10, 4'h9, 1'b0, 16'd6);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h20, 4'hA, 1'b0);
        checkOutput("rs_reset", 1'b0, 8'h00, 4'h0, 1'b1, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h7E, 4'h3, 1'b1);
        checkOutput("rs_after", 1'b1, 8'h7E, 4'h3, 1'b1, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        checkOutput("rs_drain", 1'b0, 8'h7E, 4'h0, 1'b1, 16'd1);

        // Saturation on the 4-bit counter instance: 20 idle cycles after reset
        checkVal("sat_reset", {12'd0, satCnt}, 16'd0);
        satReset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
            if (i == 3)  checkVal("sat_cnt3", {12'd0, satCnt}, 16'd3);
            if (i == 14) checkVal("sat_cnt14", {12'd0, satCnt}, 16'd14);
            if (i == 15) checkVal("sat_cnt15", {12'd0, satCnt}, 16'd15);
            if (i == 20) checkVal("sat_cnt20", {12'd0, satCnt}, 16'd15);
        end
        checkVal("sat_valid", {15'd0, satIf.out_valid}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that succeeds the fixed-field MEM/WB-style latch used between stages of the 8-bit pipelined core. It carries one data bundle and one control bundle per transfer with a valid/ready handshake, a synchronous flush, and bubble insertion. Control bits of a bubble are forced to zero so downstream stages never see a spurious write. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with the stage-specific fields packed into `in_data` / `in_ctrl` by the instantiating stage.

## Interface
- `DATA_W`, 8 — width of the payload bundle (results, PC+1, register index, ...).
- `CTRL_W`, 4 — width of the control bundle (RegWrite, ResultSrc, MemWrite, ...); forced to zero on bubbles.
- `CNT_W`, 16 — width of the bubble performance counter.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `reset` input 1 — synchronous, active-high; sampled on the rising edge of `clk`.
- `flush` input 1 — synchronous kill of every entry held in the stage.
- `in_valid` input 1 — upstream offers a transfer.
- `in_ready` output 1 — stage can accept a transfer this cycle.
- `in_data` input DATA_W — upstream payload.
- `in_ctrl` input CTRL_W — upstream control bits.
- `out_valid` output 1 — stage presents a valid entry.
- `out_ready` input 1 — downstream consumes the presented entry.
- `out_data` output DATA_W — presented payload.
- `out_ctrl` output CTRL_W — presented control; equals 0 whenever `out_valid`=0.
- `bubble_cnt` output CNT_W — count of cycles with `out_valid`=0 since reset; saturates at all-ones.

## Operation
- Accept: `in_valid && in_ready` at the edge. Consume: `out_valid && out_ready` at the edge.
- Main entry (`m_valid`, `m_data`, `m_ctrl`) drives the outputs directly from registers; no combinational path from `in_*` to `out_*`.
- States without skid: EMPTY (`m_valid`=0), FULL (`m_valid`=1).
  - EMPTY + accept -> FULL.
  - FULL + consume + no accept -> EMPTY.
  - FULL + consume + accept -> FULL with new data.
  - FULL + no consume -> hold.
- States with skid (see Configuration): EMPTY, FULL, SKID (main and skid both valid).
  - FULL + accept + no consume -> SKID; the incoming entry goes to the skid register.
  - SKID + consume -> FULL; the skid entry moves to main.
  - SKID never accepts.
- Flush: next state is EMPTY (and skid cleared). An input accepted in the flush cycle is dropped. An entry consumed in the flush cycle counts as delivered.
- Priority: `reset` > `flush` > accept/consume.
- `out_ctrl` = `m_ctrl` when `m_valid`=1, else 0.
- `out_data` holds its last value while invalid, and is not cleared by flush. It is cleared to 0 by reset only.
- `bubble_cnt` increments each cycle `out_valid`=0 (registered value) and is not cleared by flush.

## Timing
- Latency: a transfer accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput: one transfer per cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `out_data`=0, `out_ctrl`=0, `bubble_cnt`=0, skid empty, `in_ready`=1.
- Without skid, `in_ready` = `!m_valid || out_ready` (combinational from `out_ready`).
- With skid, `in_ready` = `!s_valid` (registered; no combinational input-to-output path).
- Handshake rule: `in_data`/`in_ctrl` are sampled only on accept. Once `out_valid`=1, the outputs stay stable until consume or flush.
- Reset asserted mid-transfer discards all entries on that edge, regardless of `in_valid` / `out_ready`.

## Configuration
- `PIPE_SKID_EN` defined: a one-entry skid register (`s_valid`, `s_data`, `s_ctrl`) is compiled in and `in_ready` is registered. Full throughput is retained under backpressure and the ready path is cut for timing closure.
- `PIPE_SKID_EN` undefined: no skid storage; `in_ready` is combinational as above. The SKID state does not exist.

## Test plan
- Reset then stream: DATA_W=8, inputs 0x11,0x22,0x33 on consecutive cycles with `out_ready`=1 -> `out_data` 0x11,0x22,0x33 one cycle later each, `out_valid` continuous, `bubble_cnt` stops at 1.
- Backpressure: FULL with 0xA5, `out_ready`=0, offer 0x5A -> no-skid: `in_ready`=0 and 0xA5 held. Skid: 0x5A accepted, then `in_ready`=0. On release, 0xA5 then 0x5A emerge.
- Flush: FULL with `in_ctrl`=4'b1011 and `flush`=1 while offering a new entry -> next cycle `out_valid`=0, `out_ctrl`=0, `out_data` unchanged; the offered entry never appears.
- Reset mid-operation: SKID state, assert `reset` one cycle -> all outputs at reset values, `in_ready`=1; a subsequent 0x7E passes normally.
- Bubble counter saturation: CNT_W=4, idle 20 cycles -> `bubble_cnt`=4'hF, no wrap.
- Simultaneous accept and consume in FULL: 0x01 presented, `out_ready`=1, offer 0x02 -> next cycle `out_data`=0x02, `out_valid` stays 1.
